uart_frame_buffer: RTL and testbench
====================================

UART_FRAME_BUFFER -- requirements
Module: uart_frame_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of bytes per frame, legal range 2..16.
REQ-002 Parameter DATA_W, default 8, width of one received or transmitted word.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 rx_data  input  DATA_W  received word, valid only while rx_ready is high.
REQ-006 rx_ready  input  1  one-cycle strobe from the UART receiver.
REQ-007 clear  input  1  one-cycle pulse that empties the frame and aborts any dump.
REQ-008 dump  input  1  one-cycle pulse, from a debounced button, that requests transmission of the stored frame.
REQ-009 tx_busy  input  1  transmitter busy flag.
REQ-010 tx_start  output  1  one-cycle strobe to the transmitter.
REQ-011 tx_data  output  DATA_W  word presented to the transmitter; held stable from tx_start until tx_busy falls.
REQ-012 count  output  $clog2(DEPTH+1)  number of stored words.
REQ-013 full  output  1  high when count == DEPTH.
REQ-014 dumping  output  1  high whenever the state is not IDLE.
REQ-015 overflow  output  1  sticky flag for a dropped received word.

Function
REQ-016 The state machine SHALL have the states IDLE, LOAD, WAIT_BUSY and WAIT_DONE.
REQ-017 In IDLE, rx_ready with count < DEPTH SHALL write rx_data to mem[count] and increment count in the same cycle.
REQ-018 A dropped word (rx_ready with full, or rx_ready in any state other than IDLE) SHALL leave memory unchanged and set overflow.
REQ-019 In IDLE, dump with count == 0 (after any same-cycle write) SHALL be ignored.
REQ-020 Otherwise, dump in IDLE SHALL clear the read index and move to LOAD.
REQ-021 A same-cycle rx_ready with count < DEPTH SHALL be stored first and included in the dump.
REQ-022 In LOAD, with tx_busy low, the block SHALL drive tx_data = mem[idx], pulse tx_start for exactly one cycle and move to WAIT_BUSY.
REQ-023 In LOAD, with tx_busy high, the block SHALL stay in LOAD with tx_start low.
REQ-024 WAIT_BUSY SHALL move to WAIT_DONE on the first cycle tx_busy is high.
REQ-025 WAIT_DONE SHALL, on the first cycle tx_busy is low, increment idx and return to LOAD.
REQ-026 When idx reaches count (checksum phase excluded), WAIT_DONE SHALL instead return to IDLE with count = 0.
REQ-027 Words SHALL be transmitted oldest first: index 0 first, index count-1 last.
REQ-028 Minimum latency from a dump pulse to tx_start SHALL be 2 cycles: dump sampled, then LOAD, then tx_start.
REQ-029 clear in any state SHALL, on the next edge, force IDLE, count = 0, idx = 0, tx_start = 0 and overflow = 0.
REQ-030 clear SHALL win over simultaneous rx_ready or dump; the received word is dropped but overflow is not set.
REQ-031 Memory contents after clear are don't-care; they SHALL never be transmitted unless rewritten.
REQ-032 full and count SHALL be updated registers, valid in the cycle after the write.

Reset
REQ-033 rst_n low SHALL immediately force state = IDLE, count = 0, idx = 0, tx_start = 0, tx_data = 0, overflow = 0 and, when FRAME_CHECKSUM_EN is defined, the checksum accumulator = 0.
REQ-034 Reset asserted mid-dump SHALL abort the dump with no further tx_start pulses.
REQ-035 Release of rst_n SHALL be synchronised externally; the block imposes no extra cycles after release.

Configuration
REQ-036 With macro FRAME_CHECKSUM_EN defined, an accumulator SHALL hold the XOR of all stored words.
REQ-037 The accumulator SHALL be updated on each write and cleared by clear, reset and dump completion.
REQ-038 With FRAME_CHECKSUM_EN defined, after the last data word one extra word equal to the accumulator SHALL be sent via LOAD/WAIT_BUSY/WAIT_DONE before IDLE.
REQ-039 Without FRAME_CHECKSUM_EN, exactly count words SHALL be sent, and no accumulator logic SHALL exist.

Structure
REQ-040 Package uart_frame_pkg SHALL hold the state enum (state_t) and the default constants DEPTH_DEF = 4 and DATA_W_DEF = 8.
REQ-041 One sub-module, frame_store, SHALL hold the DEPTH x DATA_W register array with one write port and a combinational read mux; control stays in uart_frame_buffer.

Verification
REQ-042 Frame and dump: rx bytes 0x11, 0x22, 0x33, 0x44, then dump, with a busy model of 10 cycles -> tx_data sequence 0x11, 0x22, 0x33, 0x44; four tx_start pulses; count returns to 0.
REQ-043 Overflow: five rx strobes with DEPTH = 4, fifth = 0x55 -> full = 1, overflow = 1, dump sends only the first four words; clear -> overflow = 0.
REQ-044 Empty and simultaneous: dump with count = 0 -> no tx_start; dump together with rx 0xA5 on an empty buffer -> exactly one word, 0xA5, sent.
REQ-045 Abort: clear during WAIT_DONE of word 2 -> no further tx_start, dumping = 0 next cycle, count = 0; same check repeated with rst_n low mid-dump.
REQ-046 Checksum (FRAME_CHECKSUM_EN): bytes 0x0F, 0xF0, 0x3C -> fourth transmitted word 0xC3; rx_ready during dump -> overflow = 1.
REQ-047 DEPTH = 16 sweep: 16 incrementing bytes -> sent in order, full = 1 before the dump, count width = 5 bits.

Source files
------------

// File: rtl/uart_frame_buffer_pkg.sv
// Shared types and default sizing for the UART frame buffer.
// The optional checksum word is enabled by defining FRAME_CHECKSUM_EN.
package uart_frame_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   localparam int unsigned DEPTH_DEF  = 4;
   localparam int unsigned DATA_W_DEF = 8;

endpackage

// File: rtl/uart_frame_buffer_if.sv
// Receiver / transmitter / control bundle of the UART frame buffer.
// The slave modport is the buffer's view; the master modport is the surrounding logic's view.
interface uart_frame_buffer_if
   import uart_frame_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] rx_data;
   logic              rx_ready;
   logic              clear;
   logic              dump;
   logic              tx_busy;
   logic              tx_start;
   logic [DATA_W-1:0] tx_data;
   logic [CW-1:0]     count;
   logic              full;
   logic              dumping;
   logic              overflow;

   modport master (
      output rx_data, rx_ready, clear, dump, tx_busy,
      input  tx_start, tx_data, count, full, dumping, overflow
   );

   modport slave (
      input  rx_data, rx_ready, clear, dump, tx_busy,
      output tx_start, tx_data, count, full, dumping, overflow
   );

endinterface

// File: rtl/uart_frame_buffer_frame_store.sv
// DEPTH x DATA_W word store: one synchronous write port, one combinational read port.
// Contents are never reset; the controller only reads indices it has written.
module frame_store #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned AW     = 2
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_frame_buffer.sv
// Collects received UART words into a frame and replays it to the transmitter on dump.
// Define FRAME_CHECKSUM_EN to append an XOR checksum word after the data words.
module uart_frame_buffer
   import uart_frame_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   uart_frame_buffer_if.slave bus
);

   localparam int unsigned CW      = $clog2(DEPTH + 1);
   localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   state_t            state_q;
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     idx_q;
   logic              tx_start_q;
   logic [DATA_W-1:0] tx_data_q;
   logic              overflow_q;
   logic              full_q;

   logic              wr_en;
   logic              drop;
   logic [CW-1:0]     count_d;
   logic [CW-1:0]     idx_d;
   logic              frame_done;
   logic              word_end;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] tx_word;

`ifdef FRAME_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q;
`endif

   frame_store #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .AW     (AW)
   ) u_store (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (count_q[AW-1:0]),
      .wdata_i (bus.rx_data),
      .raddr_i (idx_q[AW-1:0]),
      .rdata_o (rd_data)
   );

   always_comb begin
      wr_en    = (state_q == IDLE) && bus.rx_ready && !bus.clear && (count_q != DEPTH_C);
      drop     = bus.rx_ready && !bus.clear && !wr_en;
      count_d  = wr_en ? count_q + CW'(1) : count_q;
      idx_d    = idx_q + CW'(1);
      word_end = (state_q == WAIT_DONE) && !bus.tx_busy;
`ifdef FRAME_CHECKSUM_EN
      // idx == count marks the checksum word, sent after the last data word.
      frame_done = (idx_q == count_q);
      tx_word    = frame_done ? csum_q : rd_data;
`else
      frame_done = (idx_d == count_q);
      tx_word    = rd_data;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         count_q    <= '0;
         idx_q      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         overflow_q <= 1'b0;
         full_q     <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         if (bus.clear) begin
            state_q    <= IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            full_q     <= 1'b0;
         end else begin
            if (drop) begin
               overflow_q <= 1'b1;
            end
            unique case (state_q)
               IDLE: begin
                  count_q <= count_d;
                  full_q  <= (count_d == DEPTH_C);
                  // A same-cycle write is already counted, so it joins the dump.
                  if (bus.dump && (count_d != '0)) begin
                     idx_q   <= '0;
                     state_q <= LOAD;
                  end
               end
               LOAD: begin
                  if (!bus.tx_busy) begin
                     tx_data_q  <= tx_word;
                     tx_start_q <= 1'b1;
                     state_q    <= WAIT_BUSY;
                  end
               end
               WAIT_BUSY: begin
                  if (bus.tx_busy) begin
                     state_q <= WAIT_DONE;
                  end
               end
               WAIT_DONE: begin
                  if (!bus.tx_busy) begin
                     if (frame_done) begin
                        state_q <= IDLE;
                        count_q <= '0;
                        idx_q   <= '0;
                        full_q  <= 1'b0;
                     end else begin
                        idx_q   <= idx_d;
                        state_q <= LOAD;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

`ifdef FRAME_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q <= '0;
      end else if (bus.clear || (word_end && frame_done)) begin
         csum_q <= '0;
      end else if (wr_en) begin
         csum_q <= csum_q ^ bus.rx_data;
      end
   end
`endif

   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.count    = count_q;
   assign bus.full     = full_q;
   assign bus.dumping  = (state_q != IDLE);
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_frame_buffer.sv
// Randomised bench for uart_frame_buffer against a queue-based frame model.
// Builds with or without FRAME_CHECKSUM_EN; the model follows the same macro.
module tb_uart_frame_buffer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_frame_buffer_if #(.DEPTH(4),  .DATA_W(8)) ba ();
   uart_frame_buffer_if #(.DEPTH(16), .DATA_W(8)) bb ();

   uart_frame_buffer #(.DEPTH(4),  .DATA_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
   uart_frame_buffer #(.DEPTH(16), .DATA_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));

   int errs = 0;
   int checks = 0;
   int hold_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Transmitter models: busy for 10 cycles after each start strobe.
   logic [7:0] obs_a[$];
   logic [7:0] obs_b[$];
   int busy_a = 0, busy_b = 0;
   logic [7:0] cap_a = '0, cap_b = '0;
   logic prev_a = 1'b0, prev_b = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_a = 0; ba.tx_busy = 1'b0; prev_a = 1'b0;
      end else begin
         if (ba.tx_busy && ba.tx_data !== cap_a) hold_err++;
         if (ba.tx_start && prev_a) hold_err++;
         prev_a = ba.tx_start;
         if (ba.tx_start) begin
            obs_a.push_back(ba.tx_data); cap_a = ba.tx_data; busy_a = 10; ba.tx_busy = 1'b1;
         end else if (busy_a > 0) begin
            busy_a--;
            if (busy_a == 0) ba.tx_busy = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_b = 0; bb.tx_busy = 1'b0; prev_b = 1'b0;
      end else begin
         if (bb.tx_busy && bb.tx_data !== cap_b) hold_err++;
         if (bb.tx_start && prev_b) hold_err++;
         prev_b = bb.tx_start;
         if (bb.tx_start) begin
            obs_b.push_back(bb.tx_data); cap_b = bb.tx_data; busy_b = 10; bb.tx_busy = 1'b1;
         end else if (busy_b > 0) begin
            busy_b--;
            if (busy_b == 0) bb.tx_busy = 1'b0;
         end
      end
   end

   // Frame model for the DEPTH=4 instance.
   logic [7:0] mq[$];
   logic [7:0] expq[$];
   bit m_act = 0;
   bit m_ovf = 0;

   function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
      logic [7:0] x = '0;
      foreach (q[i]) x ^= q[i];
      return x;
   endfunction

   task automatic cyc(input logic rx, input logic [7:0] d, input logic dmp, input logic clr);
      ba.rx_ready = rx; ba.rx_data = d; ba.dump = dmp; ba.clear = clr;
      if (clr) begin
         mq.delete(); m_ovf = 0; m_act = 0;
      end else begin
         if (rx) begin
            if (!m_act && mq.size() < 4) mq.push_back(d);
            else m_ovf = 1;
         end
         if (dmp && !m_act && mq.size() > 0) begin
            expq = mq;
`ifdef FRAME_CHECKSUM_EN
            expq.push_back(xor_of(mq));
`endif
            m_act = 1;
            obs_a.delete();
         end
      end
      @(negedge clk);
      ba.rx_ready = 1'b0; ba.dump = 1'b0; ba.clear = 1'b0;
   endtask

   task automatic wait_tx(input int n);
      int t = 0;
      while (obs_a.size() < n && t < 1000) begin @(negedge clk); t++; end
      if (t >= 1000) chk("tx_wait_timeout", 32'(obs_a.size()), 32'(n));
   endtask

   task automatic finish(input string tag);
      int t = 0;
      while (ba.dumping && t < 3000) begin @(negedge clk); t++; end
      if (t >= 3000) chk({tag, "_timeout"}, 32'(ba.dumping), 32'(0));
      if (m_act) begin
         chk({tag, "_words"}, 32'(obs_a.size()), 32'(expq.size()));
         foreach (expq[i])
            chk({tag, "_data"}, (i < obs_a.size()) ? 32'(obs_a[i]) : 32'hxxxx_xxxx, 32'(expq[i]));
      end else begin
         chk({tag, "_nowords"}, 32'(obs_a.size()), 32'(0));
      end
      m_act = 0; mq.delete();
      chk({tag, "_count"}, 32'(ba.count), 32'(0));
      chk({tag, "_ovf"}, 32'(ba.overflow), 32'(m_ovf));
   endtask

   initial begin
      int n, simul;
      ba.rx_ready = 1'b0; ba.rx_data = '0; ba.dump = 1'b0; ba.clear = 1'b0;
      bb.rx_ready = 1'b0; bb.rx_data = '0; bb.dump = 1'b0; bb.clear = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_count", 32'(ba.count), 32'(0));
      chk("rst_dumping", 32'(ba.dumping), 32'(0));
      chk("rst_txdata", 32'(ba.tx_data), 32'(0));
      chk("rst_flags", 32'({ba.full, ba.overflow, ba.tx_start}), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Basic frame with latency check.
      cyc(1, 8'h11, 0, 0); cyc(1, 8'h22, 0, 0); cyc(1, 8'h33, 0, 0); cyc(1, 8'h44, 0, 0);
      chk("frame_full", 32'(ba.full), 32'(1));
      chk("frame_count", 32'(ba.count), 32'(4));
      cyc(0, 8'h00, 1, 0);
      chk("lat_dumping", 32'(ba.dumping), 32'(1));
      chk("lat_nostart", 32'(ba.tx_start), 32'(0));
      @(negedge clk);
      chk("lat_start", 32'(ba.tx_start), 32'(1));
      chk("lat_data", 32'(ba.tx_data), 32'h11);
      finish("frame");

      // Overflow on the fifth word.
      cyc(1, 8'h11, 0, 0); cyc(1, 8'h22, 0, 0); cyc(1, 8'h33, 0, 0); cyc(1, 8'h44, 0, 0);
      cyc(1, 8'h55, 0, 0);
      chk("ovf_full", 32'(ba.full), 32'(1));
      chk("ovf_flag", 32'(ba.overflow), 32'(1));
      cyc(0, 8'h00, 1, 0);
      finish("ovf");
      cyc(0, 8'h00, 0, 1);
      chk("ovf_clear", 32'(ba.overflow), 32'(0));

      // Empty dump, then dump with a simultaneous write.
      obs_a.delete();
      cyc(0, 8'h00, 1, 0);
      repeat (20) @(negedge clk);
      chk("empty_nostart", 32'(obs_a.size()), 32'(0));
      chk("empty_idle", 32'(ba.dumping), 32'(0));
      cyc(1, 8'hA5, 1, 0);
      finish("simul");
      chk("simul_first", (obs_a.size() > 0) ? 32'(obs_a[0]) : 32'hxxxx_xxxx, 32'hA5);

`ifdef FRAME_CHECKSUM_EN
      cyc(1, 8'h0F, 0, 0); cyc(1, 8'hF0, 0, 0); cyc(1, 8'h3C, 0, 0);
      cyc(0, 8'h00, 1, 0);
      wait_tx(1);
      cyc(1, 8'h99, 0, 0);
      chk("csum_rxovf", 32'(ba.overflow), 32'(1));
      finish("csum");
      chk("csum_word", (obs_a.size() > 3) ? 32'(obs_a[3]) : 32'hxxxx_xxxx, 32'hC3);
      cyc(0, 8'h00, 0, 1);
`endif

      // Clear while waiting for the second word to finish.
      cyc(1, 8'h01, 0, 0); cyc(1, 8'h02, 0, 0); cyc(1, 8'h03, 0, 0); cyc(1, 8'h04, 0, 0);
      cyc(0, 8'h00, 1, 0);
      wait_tx(2);
      repeat (3) @(negedge clk);
      cyc(0, 8'h00, 0, 1);
      chk("clr_dumping", 32'(ba.dumping), 32'(0));
      chk("clr_count", 32'(ba.count), 32'(0));
      repeat (40) @(negedge clk);
      chk("clr_nomore", 32'(obs_a.size()), 32'(2));

      // Reset mid-dump.
      cyc(1, 8'h07, 0, 0); cyc(1, 8'h08, 0, 0); cyc(1, 8'h09, 0, 0);
      cyc(0, 8'h00, 1, 0);
      wait_tx(1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstmid_dumping", 32'(ba.dumping), 32'(0));
      chk("rstmid_count", 32'(ba.count), 32'(0));
      chk("rstmid_txdata", 32'(ba.tx_data), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      mq.delete(); m_ovf = 0; m_act = 0;
      repeat (40) @(negedge clk);
      chk("rstmid_nomore", 32'(obs_a.size()), 32'(1));

      // Randomised frames.
      for (int it = 0; it < 25; it++) begin
         obs_a.delete(); expq.delete();
         n = int'($urandom_range(0, 6));
         simul = int'($urandom_range(0, 1));
         for (int k = 0; k < n; k++)
            cyc(1, 8'($urandom), logic'(simul == 1 && k == n - 1), 0);
         if (!(simul == 1 && n > 0)) cyc(0, 8'h00, 1, 0);
         if (m_act && $urandom_range(0, 1) == 1) begin
            wait_tx(1);
            cyc(1, 8'($urandom), 0, 0);
         end
         finish("rnd");
         cyc(0, 8'h00, 0, 1);
      end
      chk("rnd_ovfclr", 32'(ba.overflow), 32'(0));

      // DEPTH=16 sweep.
      for (int i = 0; i < 16; i++) begin
         bb.rx_ready = 1'b1; bb.rx_data = 8'(i);
         @(negedge clk);
      end
      bb.rx_ready = 1'b0;
      chk("d16_full", 32'(bb.full), 32'(1));
      chk("d16_count", 32'(bb.count), 32'(16));
      obs_b.delete();
      bb.dump = 1'b1;
      @(negedge clk);
      bb.dump = 1'b0;
      begin
         int t = 0;
         while (bb.dumping && t < 5000) begin @(negedge clk); t++; end
         if (t >= 5000) chk("d16_timeout", 32'(bb.dumping), 32'(0));
      end
`ifdef FRAME_CHECKSUM_EN
      chk("d16_words", 32'(obs_b.size()), 32'(17));
      chk("d16_csum", (obs_b.size() > 16) ? 32'(obs_b[16]) : 32'hxxxx_xxxx, 32'(0));
`else
      chk("d16_words", 32'(obs_b.size()), 32'(16));
`endif
      for (int i = 0; i < 16; i++)
         chk("d16_data", (i < obs_b.size()) ? 32'(obs_b[i]) : 32'hxxxx_xxxx, 32'(i));
      chk("d16_count_end", 32'(bb.count), 32'(0));

      chk("tx_hold_pulse", 32'(hold_err), 32'(0));
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
